// File: rtl/rcs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : rcs_pkg                                                   |
// | Brief  : Shared constants and FSM state type for the sequential    |
// |          ripple-carry subtractor (rcs_seq_ctrl / rcs_slice).       |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package rcs_pkg;

  // Default operand width and shared-slice width.
  localparam int RCS_DATA_W  = 32;
  localparam int RCS_SLICE_W = 8;

  // Sequencer states; encodings are fixed so that they stay stable in
  // waveforms and in any external debug tooling.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } rcs_state_e;

endpackage : rcs_pkg
`default_nettype wire

// File: rtl/rcs_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : rcs_slice                                                 |
// | Brief  : Combinational W-bit ripple-carry subtract slice.          |
// |          {carry, sum} = a + ~b + carry_start                       |
// | Ports  : a           in  W  minuend slice                          |
// |          b           in  W  subtrahend slice (inverted internally) |
// |          carry_start in  1  carry-in (1 = no borrow in)            |
// |          sum         out W  difference slice                       |
// |          carry       out 1  carry-out (1 = no borrow out)          |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module rcs_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         carry_start,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W-1:0] w_nb;
  logic [W:0]   w_c;

  assign w_nb   = ~b;
  assign w_c[0] = carry_start;

  // Explicit full-adder chain so the slice maps to a true ripple
  // structure rather than a tool-chosen adder architecture.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]   = a[i] ^ w_nb[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & w_nb[i]) | (a[i] & w_c[i]) | (w_nb[i] & w_c[i]);
  end

  assign carry = w_c[W];

endmodule : rcs_slice
`default_nettype wire

// File: rtl/rcs_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : rcs_seq_ctrl                                              |
// | Brief  : Multi-cycle subtractor diff = a - b. One shared SLICE_W   |
// |          subtract slice is stepped LSB slice first, carry held in  |
// |          a register between steps. valid/ready on both sides.      |
// | Ports  : clk, rst_n (async, active-low)                            |
// |          in_valid/in_ready, a, b      operand handshake            |
// |          out_valid/out_ready, diff    result handshake             |
// |          carry  final carry-out (1 = a >= b unsigned)              |
// |          busy   high in RUN or DONE                                |
// |          ovf    signed overflow, only with RCS_SEQ_OVF_EN defined  |
// | Config : `define RCS_SEQ_OVF_EN adds the ovf port and logic        |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module rcs_seq_ctrl
  import rcs_pkg::*;
#(
  parameter int DATA_W  = RCS_DATA_W,
  parameter int SLICE_W = RCS_SLICE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] diff,
  output logic              carry,
`ifdef RCS_SEQ_OVF_EN
  output logic              ovf,
`endif
  output logic              busy
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSLICE - 1);

  rcs_state_e r_state;
  rcs_state_e w_state_nxt;

  logic [IDX_W-1:0]               r_idx;
  logic                           r_cin;
  logic [NSLICE-1:0][SLICE_W-1:0] r_a;
  logic [NSLICE-1:0][SLICE_W-1:0] r_b;
  logic [NSLICE-1:0][SLICE_W-1:0] r_diff;
  logic                           r_carry;

  logic [SLICE_W-1:0] w_d;
  logic               w_c;
  logic               w_accept;
  logic               w_step;
  logic               w_last;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_step   = (r_state == S_RUN);
  assign w_last   = w_step && (r_idx == C_LAST_IDX);

  // Shared slice: operands selected by the current slice index.
  rcs_slice #(
    .W (SLICE_W)
  ) u_slice (
    .a           (r_a[r_idx]),
    .b           (r_b[r_idx]),
    .carry_start (r_cin),
    .sum         (w_d),
    .carry       (w_c)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_idx == C_LAST_IDX) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_cin   <= 1'b1;
      r_a     <= '0;
      r_b     <= '0;
      r_diff  <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_idx  <= '0;
      r_cin  <= 1'b1;
      // Cleared so partially built results never show stale slices.
      r_diff <= '0;
    end else if (w_step) begin
      r_diff[r_idx] <= w_d;
      r_cin         <= w_c;
      if (w_last) begin
        r_idx   <= '0;
        r_carry <= w_c;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign diff  = r_diff;
  assign carry = r_carry;

`ifdef RCS_SEQ_OVF_EN
  // On the last step the slice MSB is the result sign bit.
  logic r_ovf;
  logic w_ovf_nxt;

  assign w_ovf_nxt = (r_a[NSLICE-1][SLICE_W-1] != r_b[NSLICE-1][SLICE_W-1]) &
                     (w_d[SLICE_W-1] != r_a[NSLICE-1][SLICE_W-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= w_ovf_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule : rcs_seq_ctrl
`default_nettype wire

// File: tb/tb_rcs_seq_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_rcs_seq_ctrl                                           |
// | Brief  : Self-checking bench for rcs_seq_ctrl (32-bit, 8-bit       |
// |          slice). Directed vectors plus randomized operations are   |
// |          compared against an arithmetic reference model.           |
// | Config : honours RCS_SEQ_OVF_EN for the ovf port                   |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module tb_rcs_seq_ctrl;

  localparam int DATA_W  = 32;
  localparam int SLICE_W = 8;
  localparam int NSLICE  = DATA_W / SLICE_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] diff;
  logic              carry;
  logic              busy;
`ifdef RCS_SEQ_OVF_EN
  logic              ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rcs_seq_ctrl #(
    .DATA_W  (DATA_W),
    .SLICE_W (SLICE_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .carry     (carry),
`ifdef RCS_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next active edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain modular arithmetic on the full operands.
  function automatic logic [DATA_W-1:0] ref_diff(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return x - y;
  endfunction

  function automatic logic ref_carry(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    return x >= y;
  endfunction

  function automatic logic ref_ovf(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y);
    longint sd;
    sd = longint'($signed(x)) - longint'($signed(y));
    return (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
  endfunction

  // One full operation: accept, latency, result, optional backpressure,
  // then release and check the return to IDLE.
  task automatic run_op(input logic [DATA_W-1:0] op_a, input logic [DATA_W-1:0] op_b,
                        input int stall, input string tag);
    int lat;
    int w;
    logic [DATA_W-1:0] e_diff;
    logic              e_carry;
    e_diff  = ref_diff(op_a, op_b);
    e_carry = ref_carry(op_a, op_b);

    w = 0;
    while (!in_ready && w < 20) begin
      tick();
      w++;
    end
    check({tag, " in_ready_wait"}, 64'(in_ready), 64'd1);

    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    tick();
    // Operands are latched; scramble inputs and keep in_valid asserted.
    a = $urandom;
    b = $urandom;
    check({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    check({tag, " in_ready_run"}, 64'(in_ready), 64'd0);

    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
      a = $urandom;
      b = $urandom;
    end
    check({tag, " latency"}, 64'(lat), 64'(NSLICE));
    check({tag, " diff"}, 64'(diff), 64'(e_diff));
    check({tag, " carry"}, 64'(carry), 64'(e_carry));
`ifdef RCS_SEQ_OVF_EN
    check({tag, " ovf"}, 64'(ovf), 64'(ref_ovf(op_a, op_b)));
`endif

    for (int i = 0; i < stall; i++) begin
      tick();
      a = $urandom;
      b = $urandom;
      check({tag, " stall_valid"}, 64'(out_valid), 64'd1);
      check({tag, " stall_diff"}, 64'(diff), 64'(e_diff));
      check({tag, " stall_carry"}, 64'(carry), 64'(e_carry));
      check({tag, " stall_in_ready"}, 64'(in_ready), 64'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " idle_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, " idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #23;
    check("rst diff", 64'(diff), 64'd0);
    check("rst carry", 64'(carry), 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
`ifdef RCS_SEQ_OVF_EN
    check("rst ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Directed vectors.
    run_op(32'h0000_0005, 32'h0000_0003, 0,  "v1");
    run_op(32'h0000_0003, 32'h0000_0005, 0,  "v2");
    run_op(32'h0001_0000, 32'h0000_0001, 0,  "v3");
    run_op(32'h1234_5678, 32'h0FED_CBA9, 10, "v4_backpressure");
    run_op(32'h8000_0000, 32'h0000_0001, 0,  "v6a");
    run_op(32'h0000_0005, 32'h0000_0003, 0,  "v6b");
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0,  "ovf_pos");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  "equal");
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 1,  "zero_minus_max");

    // Reset in the middle of an operation, at the second RUN clock.
    in_valid = 1'b1;
    a        = 32'h1122_3344;
    b        = 32'h0101_0101;
    tick();
    in_valid = 1'b0;
    tick();
    check("midrst pre busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 64'(out_valid), 64'd0);
    check("midrst diff", 64'(diff), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    #3;
    rst_n = 1'b1;
    tick();
    run_op(32'd9, 32'd4, 0, "after_rst");

    // Randomized operations with mixed operand classes and stalls.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = ra; end
        2: begin ra = $urandom_range(0, 255); rb = $urandom_range(0, 255); end
        3: begin ra = {1'b1, 31'($urandom)}; rb = {1'b0, 31'($urandom)}; end
        default: begin ra = 32'($urandom) << (8 * $urandom_range(0, 3)); rb = 32'd1; end
      endcase
      run_op(ra, rb, $urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rcs_seq_ctrl
`default_nettype wire
